// File: rtl/fan_ctrl_multi.sv
// NUM_CH fan loops sharing one time-multiplexed incremental-PI datapath, each with a clamped PWM.
// Define FANCTRL_SPINUP_EN to force a channel fully on for 4 periods when it starts from zero.
module fan_ctrl_multi #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned FRAC_W = 6,
  parameter int unsigned COEF_W = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH-1:0]        sample_stb_i,
  input  logic [NUM_CH*DATA_W-1:0] adc_value_i,
  input  logic [NUM_CH*DATA_W-1:0] set_value_i,
  input  logic signed [COEF_W-1:0] kp_i,
  input  logic signed [COEF_W-1:0] ki_i,
  input  logic                     config_en_i,
  input  logic [DATA_W:0]          pwm_period_i,
  input  logic [DATA_W-1:0]        pwm_min_i,
  output logic [NUM_CH-1:0]        pwm_o,
  output logic [NUM_CH*DATA_W-1:0] duty_o,
  output logic                     busy_o,
  output logic [3:0]               state_o
);
  localparam int unsigned E_W   = DATA_W + 1;
  localparam int unsigned U_W   = DATA_W + FRAC_W;
  localparam int unsigned ACC_W = COEF_W + DATA_W + 3;
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StCalc, StStore} state_e;
  state_e state_q, state_d;

  logic [NUM_CH-1:0]       pend_q, pend_d, stb, req;
  logic [IDX_W-1:0]        last_q, cur_q, grant_idx, scan_idx;
  logic                    grant_valid;
  logic [DATA_W-1:0]       cur_set, cur_adc;
  logic signed [E_W-1:0]   e_q, e_new;
  logic signed [E_W-1:0]   eprev_q [NUM_CH];
  logic [U_W-1:0]          u_q [NUM_CH];
  logic [U_W-1:0]          u_sat;
  logic signed [ACC_W-1:0] acc_q, acc_d, u_ext, kp_ext, ki_ext, de_ext, e_ext;
  logic [DATA_W-1:0]       dnext_q [NUM_CH];
  logic [DATA_W-1:0]       duty_q [NUM_CH];
  logic [DATA_W-1:0]       duty_d [NUM_CH];
  logic [DATA_W-1:0]       eff [NUM_CH];
  logic [DATA_W:0]         cnt_q, cnt_d;
  logic                    wrap, run;
  logic [NUM_CH-1:0]       pwm_q, pwm_d;
  logic                    cfg_q;
`ifdef FANCTRL_SPINUP_EN
  logic [NUM_CH-1:0]       kick_act_q, kick_act_d;
  logic [1:0]              kick_cnt_q [NUM_CH];
  logic [1:0]              kick_cnt_d [NUM_CH];
`endif

  assign stb = config_en_i ? '0 : sample_stb_i;
  // A fresh strobe is visible to the arbiter in the same cycle it arrives.
  assign req = pend_q | stb;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      scan_idx = IDX_W'((int'(last_q) + k) % int'(NUM_CH));
      if (!grant_valid && req[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_valid) state_d = StLoad;
      StLoad:  state_d = StCalc;
      StCalc:  state_d = StStore;
      StStore: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (config_en_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    cur_set = set_value_i[cur_q*DATA_W +: DATA_W];
    cur_adc = adc_value_i[cur_q*DATA_W +: DATA_W];
    e_new   = $signed({1'b0, cur_set}) - $signed({1'b0, cur_adc});
    u_ext   = $signed(ACC_W'(u_q[cur_q]));
    kp_ext  = ACC_W'(kp_i);
    ki_ext  = ACC_W'(ki_i);
    e_ext   = ACC_W'(e_q);
    de_ext  = ACC_W'(e_q) - ACC_W'(eprev_q[cur_q]);
    acc_d   = u_ext + kp_ext * de_ext + ki_ext * e_ext;
    if (acc_q[ACC_W-1])            u_sat = '0;
    else if (|acc_q[ACC_W-2:U_W])  u_sat = '1;
    else                           u_sat = acc_q[U_W-1:0];
    pend_d = pend_q;
    if (state_q == StStore) pend_d[cur_q] = 1'b0;
    pend_d = pend_d | stb;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || config_en_i) begin
      pend_q <= '0;
      last_q <= LAST_IDX;
      cur_q  <= '0;
      e_q    <= '0;
      acc_q  <= '0;
      for (int n = 0; n < int'(NUM_CH); n++) begin
        u_q[n]     <= '0;
        eprev_q[n] <= '0;
        dnext_q[n] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      if (state_q == StIdle && grant_valid) begin
        cur_q  <= grant_idx;
        last_q <= grant_idx;
      end
      if (state_q == StLoad) e_q <= e_new;
      if (state_q == StCalc) acc_q <= acc_d;
      if (state_q == StStore) begin
        u_q[cur_q]     <= u_sat;
        eprev_q[cur_q] <= e_q;
        dnext_q[cur_q] <= u_sat[U_W-1:FRAC_W];
      end
    end
  end

  // PWM compare uses next-state count and duty so pwm_q lines up with cnt_q.
  always_comb begin
    wrap  = (cnt_q >= pwm_period_i);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    run   = (pwm_period_i != '0);
    for (int n = 0; n < int'(NUM_CH); n++) begin
      if (dnext_q[n] == '0)              eff[n] = '0;
      else if (dnext_q[n] < pwm_min_i)   eff[n] = pwm_min_i;
      else                               eff[n] = dnext_q[n];
      duty_d[n] = wrap ? eff[n] : duty_q[n];
`ifdef FANCTRL_SPINUP_EN
      kick_act_d[n] = kick_act_q[n];
      kick_cnt_d[n] = kick_cnt_q[n];
      if (wrap) begin
        if (eff[n] == '0) begin
          kick_act_d[n] = 1'b0;
        end else if (duty_q[n] == '0) begin
          kick_act_d[n] = 1'b1;
          kick_cnt_d[n] = 2'd0;
        end else if (kick_act_q[n]) begin
          if (kick_cnt_q[n] == 2'd3) kick_act_d[n] = 1'b0;
          else                       kick_cnt_d[n] = kick_cnt_q[n] + 2'd1;
        end
      end
      pwm_d[n] = run && (kick_act_d[n] || ({1'b0, duty_d[n]} > cnt_d));
`else
      pwm_d[n] = run && ({1'b0, duty_d[n]} > cnt_d);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || config_en_i) begin
      cnt_q <= '0;
      pwm_q <= '0;
      for (int n = 0; n < int'(NUM_CH); n++) duty_q[n] <= '0;
`ifdef FANCTRL_SPINUP_EN
      kick_act_q <= '0;
      for (int n = 0; n < int'(NUM_CH); n++) kick_cnt_q[n] <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      for (int n = 0; n < int'(NUM_CH); n++) duty_q[n] <= duty_d[n];
`ifdef FANCTRL_SPINUP_EN
      kick_act_q <= kick_act_d;
      for (int n = 0; n < int'(NUM_CH); n++) kick_cnt_q[n] <= kick_cnt_d[n];
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cfg_q <= 1'b0;
    else       cfg_q <= config_en_i;
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_duty
    assign duty_o[n*DATA_W +: DATA_W] = duty_q[n];
  end

  assign pwm_o   = pwm_q;
  assign busy_o  = (state_q != StIdle);
  assign state_o = cfg_q ? 4'hC : 4'hA;

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// Self-checking bench for fan_ctrl_multi: vector table with a result scoreboard plus
// hand-written reset, min-clamp, round-robin and config-abort sequences.
module tb_fan_ctrl_multi;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 4;
  localparam int FRAC_W = 6;
  localparam int COEF_W = 10;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     config_en;
  logic [NUM_CH-1:0]        stb;
  logic [NUM_CH*DATA_W-1:0] adc_v, set_v;
  logic signed [COEF_W-1:0] kp, ki;
  logic [DATA_W:0]          period;
  logic [DATA_W-1:0]        pmin;
  logic [NUM_CH-1:0]        pwm;
  logic [NUM_CH*DATA_W-1:0] duty;
  logic                     busy;
  logic [3:0]               state;

  always #5 clk = ~clk;

  fan_ctrl_multi #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .COEF_W(COEF_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sample_stb_i(stb), .adc_value_i(adc_v), .set_value_i(set_v),
    .kp_i(kp), .ki_i(ki), .config_en_i(config_en), .pwm_period_i(period), .pwm_min_i(pmin),
    .pwm_o(pwm), .duty_o(duty), .busy_o(busy), .state_o(state)
  );

  typedef struct {
    int ch; int sv; int av; int kp; int ki; int exp;
  } vec_t;

  vec_t vecs [11];
  int   exp_q [$];
  int   ch_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int duty_of(input int ch);
    return int'(duty[ch*DATA_W +: DATA_W]);
  endfunction

  task automatic set_ch(input int ch, input int sv, input int av);
    set_v[ch*DATA_W +: DATA_W] = DATA_W'(sv);
    adc_v[ch*DATA_W +: DATA_W] = DATA_W'(av);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb = '0;
    config_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] m);
    stb = m;
    @(negedge clk);
    stb = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hi, hi2, n, c, e, x0, x1, x3;
    rst = 1'b1; config_en = 1'b0; stb = '0; adc_v = '0; set_v = '0;
    kp = 10'sd64; ki = '0; period = 5'd19; pmin = '0;
    repeat (2) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_state", int'(state), 10);
    check("rst_busy", int'(busy), 0);

    // Strobe on the first cycle out of reset; P-only loop, period 20 cycles.
    rst = 1'b0;
    set_ch(0, 10, 4);
    pulse(4'b0001);
    check("busy_rise", int'(busy), 1);
    wait_idle("p_idle");
    n = 0;
    while (duty_of(0) != 6 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("p_duty", duty_of(0), 6);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      hi += int'(pwm[0]);
      @(negedge clk);
    end
    check("p_high_cycles", hi, 6);
    pulse(4'b0001);
    wait_idle("p2_idle");
    repeat (22) @(negedge clk);
    check("p2_duty", duty_of(0), 6);

    // Table: state carries across vectors, results go through the scoreboard.
    vecs[0]  = '{0, 10,  4,  64,  0,  6};
    vecs[1]  = '{0, 10,  4,  64,  0,  6};
    vecs[2]  = '{1, 10,  4,  64, 32,  9};
    vecs[3]  = '{1, 10,  4,  64, 32, 12};
    vecs[4]  = '{1, 10,  4,  64, 32, 15};
    vecs[5]  = '{1, 10,  4,  64, 32, 15};
    vecs[6]  = '{2,  4, 10,  64,  0,  0};
    vecs[7]  = '{3,  5,  4,  64,  0,  1};
    vecs[8]  = '{3,  4,  4,  64,  0,  0};
    vecs[9]  = '{0,  4, 10,  64,  0,  0};
    vecs[10] = '{2,  0, 10, -32,  0,  2};
    do_reset();
    period = 5'd3;
    pmin = '0;
    for (int i = 0; i < 11; i++) begin
      kp = COEF_W'(vecs[i].kp);
      ki = COEF_W'(vecs[i].ki);
      set_ch(vecs[i].ch, vecs[i].sv, vecs[i].av);
      exp_q.push_back(vecs[i].exp);
      ch_q.push_back(vecs[i].ch);
      pulse(NUM_CH'(1 << vecs[i].ch));
      wait_idle($sformatf("vec%0d_idle", i));
      repeat (6) @(negedge clk);
      c = ch_q.pop_front();
      e = exp_q.pop_front();
      check($sformatf("vec%0d_duty", i), duty_of(c), e);
    end

    // Minimum clamp: computed duty 1 widens to 3, computed 0 stays off.
    do_reset();
    period = 5'd19; pmin = 4'd3; kp = 10'sd64; ki = '0;
    set_ch(3, 5, 4);
    set_ch(2, 4, 4);
    pulse(4'b1100);
    repeat (50) @(negedge clk);
    check("min_duty3", duty_of(3), 3);
    check("min_duty2", duty_of(2), 0);
    hi = 0; hi2 = 0;
    for (int i = 0; i < 20; i++) begin
      hi  += int'(pwm[3]);
      hi2 += int'(pwm[2]);
      @(negedge clk);
    end
    check("min_high3", hi, 3);
    check("min_high2", hi2, 0);

    // Round robin with period 0: duty_o tracks duty_next one cycle later, pwm stays low.
    do_reset();
    period = '0; pmin = '0; kp = 10'sd64; ki = '0;
    set_ch(0, 7, 4);
    set_ch(1, 10, 4);
    set_ch(3, 9, 4);
    stb = 4'b1011;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) stb = '0;
      x0 = (k >= 5) ? 3 : 0;
      x1 = (k >= 17) ? 8 : ((k >= 9) ? 6 : 0);
      x3 = (k >= 13) ? 5 : 0;
      check($sformatf("rr_ch0_c%0d", k), duty_of(0), x0);
      check($sformatf("rr_ch1_c%0d", k), duty_of(1), x1);
      check($sformatf("rr_ch3_c%0d", k), duty_of(3), x3);
      check($sformatf("rr_pwm_c%0d", k), int'(pwm), 0);
      if (k == 7) begin
        set_ch(1, 12, 4);
        stb = 4'b0010;
      end
      if (k == 8) stb = '0;
    end

    // Config abort during CALC of ch2 must leave u2/e_prev2 untouched.
    do_reset();
    period = 5'd3; pmin = '0; kp = 10'sd64; ki = 10'sd32;
    set_ch(0, 6, 4);
    pulse(4'b0001);
    wait_idle("cfg_pre_idle");
    repeat (6) @(negedge clk);
    check("cfg_pre_duty0", duty_of(0), 3);
    set_ch(2, 10, 4);
    pulse(4'b0100);
    @(negedge clk);
    config_en = 1'b1;
    @(negedge clk);
    check("cfg_busy", int'(busy), 0);
    check("cfg_state", int'(state), 12);
    check("cfg_pwm", int'(pwm), 0);
    check("cfg_duty", int'(duty), 0);
    stb = 4'b0010;
    @(negedge clk);
    stb = '0;
    check("cfg_pwm_hold", int'(pwm), 0);
    config_en = 1'b0;
    @(negedge clk);
    check("cfg_exit_state", int'(state), 10);
    check("cfg_exit_duty", int'(duty), 0);
    check("cfg_exit_busy", int'(busy), 0);
    pulse(4'b0100);
    wait_idle("cfg_post_idle");
    repeat (6) @(negedge clk);
    check("cfg_post_duty2", duty_of(2), 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fan_ctrl_multi.md
Name: fan_ctrl_multi

Overview:
Multi-channel successor to the single-fan controller. It runs NUM_CH independent fan loops through one shared incremental-PI datapath that is time-multiplexed across channels by a round-robin scheduler. Each channel drives its own PWM output with a minimum-speed clamp. All PWM outputs share one period counter and update their duty only at period wrap. It sits between the per-channel ADC/setpoint interface and the fan PWM pins, and also drives the 4-bit mode code for the seven-segment decoder.

Parameters:
NUM_CH, 4, number of fan channels (1..8)
DATA_W, 4, ADC/setpoint/duty width in bits (>=4)
FRAC_W, 6, fractional bits of coefficients and integrator
COEF_W, 10, signed coefficient width (DATA_W+FRAC_W)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
sample_stb_i  in  NUM_CH  one-cycle per-channel "new ADC sample" strobe
adc_value_i  in  NUM_CH*DATA_W  packed measured values; channel n at [n*DATA_W +: DATA_W]
set_value_i  in  NUM_CH*DATA_W  packed setpoints, same packing
kp_i  in  COEF_W  signed proportional coefficient, Q(FRAC_W)
ki_i  in  COEF_W  signed integral coefficient, Q(FRAC_W)
config_en_i  in  1  config mode request
pwm_period_i  in  DATA_W+1  PWM counter top value (period = value+1 cycles)
pwm_min_i  in  DATA_W  minimum non-zero duty
pwm_o  out  NUM_CH  PWM pins
duty_o  out  NUM_CH*DATA_W  active duty per channel
busy_o  out  1  datapath not IDLE
state_o  out  4  4'hC in config mode, 4'hA in run mode

Behaviour:
- Reset (rst_i=1 at a clk_i edge): all outputs 0 except state_o=4'hA; pending flags, integrators u[n], e_prev[n] and PWM counter cleared; FSM goes to IDLE.
- Pending: a sample_stb_i[n] sets pend[n]. Pend[n] is cleared in STORE of channel n. If a strobe for n arrives in that same cycle, set wins.
- Arbiter: in IDLE with any pend set, grant the first pending index after last_served (wrapping); first grant after reset starts at 0.
- FSM IDLE->LOAD->CALC->STORE->IDLE, one cycle each.
  - LOAD: latch e = set-adc, signed DATA_W+1.
  - CALC: acc = u[n] + kp*(e-e_prev[n]) + ki*e. acc is signed, COEF_W+DATA_W+3 bits, all terms sign-extended.
  - STORE: u[n] = sat(acc) to [0, 2^(DATA_W+FRAC_W)-1]; e_prev[n] = e; duty_next[n] = u[n]>>FRAC_W.
- Latency: 4 cycles from strobe (channel idle) to duty_next written. busy_o=1 in LOAD/CALC/STORE.
- Duty clamp: eff = 0 if duty_next==0, else max(duty_next, pwm_min_i).
- PWM counter: runs 0..pwm_period_i, then wraps to 0.
  - At wrap, duty_o[n] <= eff[n]; duty never changes mid-period.
  - pwm_o[n] = (cnt < duty_o[n]), registered.
  - pwm_period_i=0: pwm_o held low.
  - duty >= period+1: pwm_o constant high.
- Config mode (config_en_i=1):
  - Aborts any LOAD/CALC at the next edge without writing state; FSM returns to IDLE.
  - While high: strobes ignored; pend, u, e_prev, duty_o cleared; pwm_o=0; state_o=4'hC.
  - Deassertion resumes run mode on the next cycle from zeroed state.
- rst_i has priority over config_en_i and everything else.

Optional Feature:
FANCTRL_SPINUP_EN
- Defined: when a channel's duty_o transitions 0 -> nonzero at wrap, it is forced fully on (pwm_o=1) for 4 complete PWM periods. It then follows duty_o. A per-channel 2-bit kick counter implements this and is cleared by reset/config. If duty returns to 0 during the kick, the kick is cancelled.
- Undefined: no kick logic; pwm_o follows duty_o immediately.

Test Plan:
- Reset: hold rst_i 2 cycles, then strobe ch0 on the same cycle rst_i deasserts -> pwm_o=0, duty_o=0, state_o=4'hA; pend0 set; busy_o rises the next cycle.
- P-only, ki=0, kp=64, ch0 set=10 adc=4, strobe -> u0=384, duty 6 after next wrap (period 19: 6 high / 14 low); same sample again -> duty stays 6.
- PI, kp=64, ki=32, set=10 adc=4, 4 strobes -> duty 9, 12, 15, then 15 (u saturates at 1023).
- Min clamp, pwm_min=3 -> a channel with computed duty 1 shows 3-cycle high pulse; computed 0 stays low.
- Round robin + collision: strobe ch1, ch3, ch0 same cycle -> served 0,1,3 in 12 cycles; ch1 re-strobed during its STORE -> served again after ch3.
- Config abort: assert config_en_i during CALC of ch2 -> u2 unchanged (0), all pwm_o=0, state_o=4'hC; deassert -> state_o=4'hA, duty_o=0.
